// File: rtl/seizure_pkg.sv
// Shared state encoding, counter widths and small helpers for the seizure detector.
package seizure_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        SEIZURE = 2'b10,
        REFRACT = 2'b11
    } sz_state_t;

    localparam int SCORE_W = 12;
    localparam int RUN_W   = 8;
    localparam int REFR_W  = 16;
    localparam int EVT_W   = 8;

    // Window and event counters stick at all-ones instead of wrapping.
    function automatic logic [RUN_W-1:0] sat_inc8(input logic [RUN_W-1:0] v);
        return (v == {RUN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter used for the refractory hold-off; stops at zero.
module down_counter
    import seizure_pkg::*;
#(
    parameter int W = REFR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seizure_detect_fsm.sv
// Window-vote seizure detector: onset after a run of hits, offset after a run of
// misses, then a fixed refractory hold-off before re-arming.
module seizure_detect_fsm
    import seizure_pkg::*;
#(
    parameter logic signed [SCORE_W-1:0] threshold         = 12'sd0,
    parameter int unsigned               on_windows        = 3,
    parameter int unsigned               off_windows       = 5,
    parameter int unsigned               refractory_cycles = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic signed [SCORE_W-1:0] weight_sum,
    input  logic                      sum_valid,
    output logic                      seizure,
    output logic                      onset,
    output logic                      offset,
    output logic [1:0]                state,
    output logic [EVT_W-1:0]          event_count
);

    localparam logic [RUN_W-1:0]  ON_N   = RUN_W'(on_windows);
    localparam logic [RUN_W-1:0]  OFF_N  = RUN_W'(off_windows);
    localparam logic [REFR_W-1:0] REFR_N = REFR_W'(refractory_cycles);

    sz_state_t         cur;
    logic [RUN_W-1:0]  run;
    logic [RUN_W-1:0]  quiet;
    logic [RUN_W-1:0]  run_nx;
    logic [RUN_W-1:0]  quiet_nx;
    logic [REFR_W-1:0] refr_count;
    logic              refr_zero;
    logic              refr_last;
    logic              refr_load;
    logic              refr_dec;
    logic              active;
    logic              hit;
    logic              miss;
    logic              go_seizure;

    // en is active-low: a high level freezes everything and drops the strobe.
    assign active   = !en;
    assign hit      = sum_valid && (weight_sum > threshold);
    assign miss     = sum_valid && !hit;
    assign run_nx   = sat_inc8(run);
    assign quiet_nx = sat_inc8(quiet);

    assign go_seizure = active && hit &&
                        (((cur == IDLE) && (ON_N == 8'd1)) ||
                         ((cur == ARMED) && (run_nx >= ON_N)));

    assign refr_load = active && (cur == SEIZURE) && miss && (quiet_nx >= OFF_N);
    assign refr_dec  = active && (cur == REFRACT) && !refr_zero;
    // Leaving on the decrement that reaches zero keeps REFRACT exactly refractory_cycles long.
    assign refr_last = (refr_count == 16'd1) || refr_zero;

    down_counter #(.W(REFR_W)) u_refr (
        .clk      (clk),
        .rst      (rst),
        .load     (refr_load),
        .load_val (REFR_N),
        .dec      (refr_dec),
        .count    (refr_count),
        .zero     (refr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= IDLE;
            run         <= '0;
            quiet       <= '0;
            seizure     <= 1'b0;
            onset       <= 1'b0;
            offset      <= 1'b0;
            event_count <= '0;
        end else begin
            onset  <= 1'b0;
            offset <= 1'b0;
            if (go_seizure) begin
                cur         <= SEIZURE;
                run         <= (cur == IDLE) ? 8'd1 : run_nx;
                quiet       <= '0;
                seizure     <= 1'b1;
                onset       <= 1'b1;
                event_count <= sat_inc8(event_count);
            end else if (active) begin
                case (cur)
                    IDLE: begin
                        if (hit) begin
                            run <= 8'd1;
                            cur <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (hit) begin
                            run <= run_nx;
                        end else if (miss) begin
                            run <= '0;
                            cur <= IDLE;
                        end
                    end
                    SEIZURE: begin
                        if (refr_load) begin
                            cur     <= REFRACT;
                            quiet   <= '0;
                            seizure <= 1'b0;
                            offset  <= 1'b1;
                        end else if (miss) begin
                            quiet <= quiet_nx;
                        end else if (hit) begin
                            quiet <= '0;
                        end
                    end
                    REFRACT: begin
                        if (refr_last) begin
                            cur   <= IDLE;
                            run   <= '0;
                            quiet <= '0;
                        end
                    end
                    default: cur <= IDLE;
                endcase
            end
        end
    end

    assign state = cur;

endmodule
